truth_table_sweeper: RTL and testbench

//   Parametrised, self-checking exhaustive stimulus engine for an N-input, 1-output combinational function.
//   On start it drives every input vector 0 .. 2^N_IN-1 in ascending order, holding each for a set number of cycles.
//   It samples the function output, compares it with an expected minterm mask, and reports pass/fail,

---
 rtl/sweep_pkg.sv | 22 ++
 rtl/sweep_hold_timer.sv | 31 +++
 rtl/truth_table_sweeper.sv | 100 ++++++++++
 tb/tb_truth_table_sweeper.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Imported by the top-level sweeper and its hold timer.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Number of input vectors an n-input function has.
   function automatic int num_vec(input int n);
      return 1 << n;
   endfunction

   // Hold-counter width; the counter must be able to reach SETTLE.
   function automatic int hold_cnt_w(input int settle);
      return (settle < 1) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Per-vector settle counter: load clears it, en advances it.
// tc flags the last settle cycle.
module sweep_hold_timer
   import sweep_pkg::*;
#(
   parameter int SETTLE = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam int W = hold_cnt_w(SETTLE);

   logic [W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= '0;
      else if (en)
         cnt <= cnt + W'(1);
   end

   assign tc = (cnt == W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector of a combinational
// function, compares its output with EXPECT and records the result.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int                         N_IN        = 4,
   parameter int                         SETTLE      = 1,
   parameter logic [num_vec(N_IN)-1:0]   EXPECT      = '0,
   parameter bit                         STOP_ON_ERR = 1'b0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   state_t state, state_n;
   logic   accept, load, advance, tc, mismatch, last;

   assign mismatch = (dut_out != EXPECT[stim]);
   assign last     = &stim;

   sweep_hold_timer #(.SETTLE(SETTLE)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (state == HOLD),
      .tc   (tc)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      load    = 1'b0;
      advance = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = HOLD;
               accept  = 1'b1;
               load    = 1'b1;
            end
         end
         HOLD: begin
            if (tc)
               state_n = SAMPLE;
         end
         SAMPLE: begin
            // The all-ones vector is terminal, so stim never wraps.
            if (last || (STOP_ON_ERR && mismatch)) begin
               state_n = DONE;
            end else begin
               state_n = HOLD;
               load    = 1'b1;
               advance = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || accept) begin
         stim       <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else if (state == SAMPLE) begin
         if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!fail_valid) begin
               fail_valid <= 1'b1;
               fail_vec   <= stim;
            end
         end
         if (advance)
            stim <= stim + N_IN'(1);
      end
   end

   assign busy = (state == HOLD) || (state == SAMPLE);
   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: five instances cover the matching,
// mismatching, stop-on-error and 2-input/long-settle configurations.
module tb_truth_table_sweeper;
   import sweep_pkg::*;

   // f(a) = (a0 ^ a1) | (a2 & a3): true for 1,2,5,6,9,10,12..15
   localparam logic [15:0] EXP_GOOD = 16'hF666;
   localparam logic [15:0] EXP_BAD  = 16'hE66E;   // bits 3 and 12 flipped

   logic clk = 1'b0;
   logic rst, start_a, start_b;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   function automatic logic f4(input logic [3:0] a);
      return (a[0] ^ a[1]) | (a[2] & a[3]);
   endfunction

   // 4-input instances
   logic [3:0] stim_g, stim_b, stim_s, fvec_g, fvec_b, fvec_s;
   logic [4:0] err_g, err_b, err_s;
   logic       busy_g, done_g, pass_g, fv_g;
   logic       busy_b, done_b, pass_b, fv_b;
   logic       busy_s, done_s, pass_s, fv_s;
   // 2-input instances
   logic [1:0] stim_x, stim_n, fvec_x, fvec_n;
   logic [2:0] err_x, err_n;
   logic       busy_x, done_x, pass_x, fv_x;
   logic       busy_n, done_n, pass_n, fv_n;

   truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECT(EXP_GOOD), .STOP_ON_ERR(1'b0)) u_good (
      .clk(clk), .rst(rst), .start(start_a), .dut_out(f4(stim_g)), .stim(stim_g),
      .busy(busy_g), .done(done_g), .pass(pass_g), .err_count(err_g),
      .fail_valid(fv_g), .fail_vec(fvec_g));

   truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECT(EXP_BAD), .STOP_ON_ERR(1'b0)) u_bad (
      .clk(clk), .rst(rst), .start(start_a), .dut_out(f4(stim_b)), .stim(stim_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .fail_valid(fv_b), .fail_vec(fvec_b));

   truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECT(EXP_BAD), .STOP_ON_ERR(1'b1)) u_stop (
      .clk(clk), .rst(rst), .start(start_a), .dut_out(f4(stim_s)), .stim(stim_s),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
      .fail_valid(fv_s), .fail_vec(fvec_s));

   truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0110), .STOP_ON_ERR(1'b0)) u_xor (
      .clk(clk), .rst(rst), .start(start_b), .dut_out(stim_x[0] ^ stim_x[1]), .stim(stim_x),
      .busy(busy_x), .done(done_x), .pass(pass_x), .err_count(err_x),
      .fail_valid(fv_x), .fail_vec(fvec_x));

   truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0110), .STOP_ON_ERR(1'b0)) u_and (
      .clk(clk), .rst(rst), .start(start_b), .dut_out(stim_n[0] & stim_n[1]), .stim(stim_n),
      .busy(busy_n), .done(done_n), .pass(pass_n), .err_count(err_n),
      .fail_valid(fv_n), .fail_vec(fvec_n));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Pulse start_a, then follow the three 4-input sweeps for up to 40 cycles.
   // Cycle n is observed on the falling edge after the n-th rising edge past the start edge.
   task automatic run_a(input bit chk_seq, input bit chk_clear, input int repulse_at,
                        output int t_g, output int t_b, output int t_s);
      t_g = -1; t_b = -1; t_s = -1;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      for (int n = 0; n <= 40; n++) begin
         if (n == 0 && chk_clear) begin
            check("clr_err",  32'(err_b),  0);
            check("clr_fv",   32'(fv_b),   0);
            check("clr_fvec", 32'(fvec_b), 0);
            check("clr_done", 32'(done_b), 0);
            check("clr_busy", 32'(busy_b), 1);
         end
         if (chk_seq && n < 32) begin
            check($sformatf("stim_c%0d", n), 32'(stim_g), 32'(n / 2));
            check($sformatf("busy_c%0d", n), 32'(busy_g), 1);
         end
         if (done_g && t_g < 0) t_g = n;
         if (done_b && t_b < 0) t_b = n;
         if (done_s && t_s < 0) t_s = n;
         if (n < 40) begin
            start_a = (n == repulse_at);
            @(negedge clk);
         end
      end
      start_a = 1'b0;
   endtask

   initial begin
      int t_g, t_b, t_s, t_x, t_n;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_stim", 32'(stim_g), 0);
      check("rst_busy", 32'(busy_g), 0);
      check("rst_done", 32'(done_g), 0);
      check("rst_pass", 32'(pass_g), 0);
      check("rst_err",  32'(err_g),  0);
      check("rst_fv",   32'(fv_g),   0);
      check("rst_fvec", 32'(fvec_g), 0);
      check("rst_state", 32'(u_good.state), 32'(IDLE));
      rst = 1'b0;

      // scenarios 1-3: matching, two mismatches, stop on first mismatch
      run_a(1'b1, 1'b0, -1, t_g, t_b, t_s);
      check("good_t",    32'(t_g),    32);
      check("good_pass", 32'(pass_g), 1);
      check("good_err",  32'(err_g),  0);
      check("good_fv",   32'(fv_g),   0);
      check("good_fvec", 32'(fvec_g), 0);
      check("good_busy", 32'(busy_g), 0);
      check("good_stim", 32'(stim_g), 15);
      check("bad_t",     32'(t_b),    32);
      check("bad_pass",  32'(pass_b), 0);
      check("bad_err",   32'(err_b),  2);
      check("bad_fv",    32'(fv_b),   1);
      check("bad_fvec",  32'(fvec_b), 3);
      check("stop_t",    32'(t_s),    8);
      check("stop_err",  32'(err_s),  1);
      check("stop_fvec", 32'(fvec_s), 3);
      check("stop_stim", 32'(stim_s), 3);
      check("stop_pass", 32'(pass_s), 0);

      // scenario 4: reset at cycle 10 of a sweep
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy", 32'(busy_g), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mr_stim",  32'(stim_g), 0);
      check("mr_busy",  32'(busy_g), 0);
      check("mr_done",  32'(done_g), 0);
      check("mr_err",   32'(err_b),  0);
      check("mr_fv",    32'(fv_b),   0);
      check("mr_fvec",  32'(fvec_b), 0);
      check("mr_state", 32'(u_good.state), 32'(IDLE));
      rst = 1'b0;
      run_a(1'b0, 1'b0, -1, t_g, t_b, t_s);
      check("post_rst_t",    32'(t_g),    32);
      check("post_rst_pass", 32'(pass_g), 1);

      // scenario 5: start re-pulsed mid-sweep is ignored; start in DONE clears results
      run_a(1'b0, 1'b1, 5, t_g, t_b, t_s);
      check("repulse_t",    32'(t_g),    32);
      check("repulse_pass", 32'(pass_g), 1);
      check("rerun_err",    32'(err_b),  2);
      check("rerun_fvec",   32'(fvec_b), 3);

      // scenario 6: 2-input, SETTLE=3, XOR and AND models
      t_x = -1; t_n = -1;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      for (int n = 0; n <= 24; n++) begin
         if (done_x && t_x < 0) t_x = n;
         if (done_n && t_n < 0) t_n = n;
         if (n < 24) @(negedge clk);
      end
      check("xor_t",    32'(t_x),    16);
      check("xor_pass", 32'(pass_x), 1);
      check("xor_err",  32'(err_x),  0);
      check("and_t",    32'(t_n),    16);
      check("and_err",  32'(err_n),  3);
      check("and_fvec", 32'(fvec_n), 1);
      check("and_pass", 32'(pass_n), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
